approx_adder_err_engine: RTL

//  Synthesizable exhaustive-sweep error-metric engine for approximate adders (SCSA and siblings).

---
 rtl/approx_adder_err_engine_pkg.sv | 40 ++++
 rtl/approx_adder_err_engine_if.sv | 12 +
 rtl/approx_adder_err_engine_err_accum.sv | 99 +++++++++
 rtl/approx_adder_err_engine.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/approx_adder_err_engine_pkg.sv
// Shared types and width helpers for the approximate-adder error engine.
// Optional worst-case tracking is enabled with ERR_WORST_EN.
package approx_metric_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Sum from the adder, including carry-out.
  function automatic int sum_w(input int w);
    return w + 1;
  endfunction

  // Signed per-pair error approx - exact.
  function automatic int err_w(input int w);
    return w + 2;
  endfunction

  // Pair counters must hold 2^(2w) itself, hence one extra bit.
  function automatic int cnt_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int abs_w(input int w);
    return 3 * w + 1;
  endfunction

  // Signed error sum: abs_w magnitude plus a sign bit.
  function automatic int esum_w(input int w);
    return 3 * w + 2;
  endfunction

  function automatic int sq_w(input int w);
    return 4 * w + 2;
  endfunction

endpackage

// File: rtl/approx_adder_err_engine_if.sv
// Operand/sum bus between the error engine (master) and the adder under test (slave).
// Used unchanged whether or not ERR_WORST_EN is defined.
interface approx_adder_err_engine_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   dut_sum;

  modport master (output op_a, output op_b, input dut_sum);
  modport slave  (input op_a, input op_b, output dut_sum);
endinterface

// File: rtl/approx_adder_err_engine_err_accum.sv
// Per-pair error calculation and registered error accumulators.
// ERR_WORST_EN adds tracking of the first pair reaching the largest |error|.
module err_accum
  import approx_metric_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      valid,
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          b,
  input  logic [sum_w(WIDTH)-1:0]   approx,
  output logic [cnt_w(WIDTH)-1:0]   case_count,
  output logic [cnt_w(WIDTH)-1:0]   err_count,
  output logic [esum_w(WIDTH)-1:0]  err_sum,
  output logic [abs_w(WIDTH)-1:0]   abs_err_sum,
  output logic [sq_w(WIDTH)-1:0]    sq_err_sum
`ifdef ERR_WORST_EN
  ,
  output logic [WIDTH:0]            max_abs_err,
  output logic [WIDTH-1:0]          worst_a,
  output logic [WIDTH-1:0]          worst_b
`endif
);

  localparam int SW  = sum_w(WIDTH);
  localparam int EW  = err_w(WIDTH);
  localparam int CW  = cnt_w(WIDTH);
  localparam int ESW = esum_w(WIDTH);
  localparam int AW  = abs_w(WIDTH);
  localparam int QW  = sq_w(WIDTH);

  logic [SW-1:0]        exact;
  logic signed [EW-1:0] e;
  logic [SW-1:0]        abs_e;
  logic [2*SW-1:0]      sq_e;

  logic [CW-1:0]  case_count_reg;
  logic [CW-1:0]  err_count_reg;
  logic [ESW-1:0] err_sum_reg;
  logic [AW-1:0]  abs_err_sum_reg;
  logic [QW-1:0]  sq_err_sum_reg;

  always_comb begin
    exact = {1'b0, a} + {1'b0, b};
    e     = $signed({1'b0, approx}) - $signed({1'b0, exact});
    // |e| never exceeds 2^(W+1)-1, so it fits the sum width.
    abs_e = e[EW-1] ? SW'(-e) : SW'(e);
    sq_e  = {{SW{1'b0}}, abs_e} * {{SW{1'b0}}, abs_e};
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      case_count_reg  <= '0;
      err_count_reg   <= '0;
      err_sum_reg     <= '0;
      abs_err_sum_reg <= '0;
      sq_err_sum_reg  <= '0;
    end else if (valid) begin
      case_count_reg  <= case_count_reg + CW'(1);
      err_count_reg   <= err_count_reg + CW'(e != '0);
      err_sum_reg     <= err_sum_reg + {{(ESW-EW){e[EW-1]}}, e};
      abs_err_sum_reg <= abs_err_sum_reg + AW'(abs_e);
      sq_err_sum_reg  <= sq_err_sum_reg + QW'(sq_e);
    end
  end

  assign case_count  = case_count_reg;
  assign err_count   = err_count_reg;
  assign err_sum     = err_sum_reg;
  assign abs_err_sum = abs_err_sum_reg;
  assign sq_err_sum  = sq_err_sum_reg;

`ifdef ERR_WORST_EN
  logic [WIDTH:0]   max_abs_reg;
  logic [WIDTH-1:0] worst_a_reg;
  logic [WIDTH-1:0] worst_b_reg;

  // Strictly-greater compare keeps the first pair among ties.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      max_abs_reg <= '0;
      worst_a_reg <= '0;
      worst_b_reg <= '0;
    end else if (valid && (abs_e > max_abs_reg)) begin
      max_abs_reg <= abs_e;
      worst_a_reg <= a;
      worst_b_reg <= b;
    end
  end

  assign max_abs_err = max_abs_reg;
  assign worst_a     = worst_a_reg;
  assign worst_b     = worst_b_reg;
`endif

endmodule

// File: rtl/approx_adder_err_engine.sv
// Exhaustive operand sweep for an external approximate adder with error accumulation.
// Define ERR_WORST_EN to add max_abs_err / worst_a / worst_b outputs.
module approx_adder_err_engine
  import approx_metric_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DUT_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  approx_adder_err_engine_if.master dut_bus,
  output logic [cnt_w(WIDTH)-1:0]   case_count,
  output logic [cnt_w(WIDTH)-1:0]   err_count,
  output logic [esum_w(WIDTH)-1:0]  err_sum,
  output logic [abs_w(WIDTH)-1:0]   abs_err_sum,
  output logic [sq_w(WIDTH)-1:0]    sq_err_sum
`ifdef ERR_WORST_EN
  ,
  output logic [WIDTH:0]            max_abs_err,
  output logic [WIDTH-1:0]          worst_a,
  output logic [WIDTH-1:0]          worst_b
`endif
);

  state_t state_reg, state_next;

  logic [WIDTH-1:0] op_a_reg, op_b_reg;
  logic             clear;
  logic             issue_v;
  logic             last_pair;
  logic             line_busy;
  logic             tap_v;
  logic [WIDTH-1:0] tap_a, tap_b;

  assign last_pair = (op_a_reg == '1) && (op_b_reg == '1);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (start)      state_next = SWEEP;
      SWEEP:      if (last_pair)  state_next = DRAIN;
      DRAIN:      if (!line_busy) state_next = DONE;
      default:                    state_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    clear   = 1'b0;
    issue_v = 1'b0;
    case (state_reg)
      IDLE:  clear = start;
      SWEEP: begin busy = 1'b1; issue_v = 1'b1; end
      DRAIN: busy = 1'b1;
      DONE:  begin done = 1'b1; clear = start; end
      default: ;
    endcase
  end

  // op_b is the low half of the pair counter, so it runs fastest.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      op_a_reg <= '0;
      op_b_reg <= '0;
    end else if (issue_v) begin
      {op_a_reg, op_b_reg} <= {op_a_reg, op_b_reg} + (2*WIDTH)'(1);
    end
  end

  assign dut_bus.op_a = op_a_reg;
  assign dut_bus.op_b = op_b_reg;

  generate
    if (DUT_LAT == 0) begin : g_no_delay
      assign tap_v     = issue_v;
      assign tap_a     = op_a_reg;
      assign tap_b     = op_b_reg;
      assign line_busy = 1'b0;
    end else begin : g_delay
      logic [DUT_LAT-1:0] v_sr_reg;
      logic [WIDTH-1:0]   a_sr_reg [DUT_LAT];
      logic [WIDTH-1:0]   b_sr_reg [DUT_LAT];

      always_ff @(posedge clk) begin
        if (rst) begin
          v_sr_reg <= '0;
        end else begin
          v_sr_reg[0] <= issue_v;
          for (int k = 1; k < DUT_LAT; k++) v_sr_reg[k] <= v_sr_reg[k-1];
        end
      end

      // Operand copies need no reset: they are only consumed when v_sr_reg says so.
      always_ff @(posedge clk) begin
        a_sr_reg[0] <= op_a_reg;
        b_sr_reg[0] <= op_b_reg;
        for (int k = 1; k < DUT_LAT; k++) begin
          a_sr_reg[k] <= a_sr_reg[k-1];
          b_sr_reg[k] <= b_sr_reg[k-1];
        end
      end

      assign tap_v     = v_sr_reg[DUT_LAT-1];
      assign tap_a     = a_sr_reg[DUT_LAT-1];
      assign tap_b     = b_sr_reg[DUT_LAT-1];
      assign line_busy = |v_sr_reg;
    end
  endgenerate

  err_accum #(.WIDTH(WIDTH)) u_accum (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .valid       (tap_v),
    .a           (tap_a),
    .b           (tap_b),
    .approx      (dut_bus.dut_sum),
    .case_count  (case_count),
    .err_count   (err_count),
    .err_sum     (err_sum),
    .abs_err_sum (abs_err_sum),
    .sq_err_sum  (sq_err_sum)
`ifdef ERR_WORST_EN
    ,
    .max_abs_err (max_abs_err),
    .worst_a     (worst_a),
    .worst_b     (worst_b)
`endif
  );

endmodule
